// File: rtl/sop_arbiter_pkg.sv
// Shared types and helpers for the sum-of-products arbiter: FSM state,
// operand widths and the round-robin pick function.
package sop_arbiter_pkg;

  localparam int SEL_W  = 3;
  localparam int MINT_W = 8;
  localparam int MAX_N  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of req searching upward from ptr, wrapping modulo n.
  // Descending scan so the smallest offset from ptr is the last to write.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                    input logic [2:0]       ptr,
                                    input int               n);
    pick_t      p;
    logic [3:0] s;
    p = '0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (i < n) begin
        s = {1'b0, ptr} + 4'(i);
        if (s >= 4'(n)) s = s - 4'(n);
        if (req[s[2:0]]) begin
          p.found = 1'b1;
          p.idx   = s[2:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/decoder38.sv
// 3-to-8 decoder with active-low outputs: y_n[a] is 0, all others 1.
module decoder38 (
  input  logic [2:0] a,
  output logic [7:0] y_n
);

  assign y_n = ~(8'b1 << a);

endmodule

// File: rtl/sop_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoder among N sum-of-products
// requesters; each transaction is IDLE -> EVAL -> RESP.
module sop_arbiter
  import sop_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N-1:0]           req,
  input  logic [SEL_W*N-1:0]     sel,
  input  logic [MINT_W*N-1:0]    mask,
  output logic [N-1:0]           gnt,
  output logic [N-1:0]           ack,
  output logic                   result,
  output logic [$clog2(N)-1:0]   result_id,
  output logic                   busy
);

  localparam int IDW = $clog2(N);

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      g_q, g_d;
  logic [SEL_W-1:0]    op_sel_q, op_sel_d;
  logic [MINT_W-1:0]   op_mask_q, op_mask_d;
  logic                result_q, result_d;
  logic [MINT_W-1:0]   dec_n;
  pick_t               pick;

  // Handshake: a requester holds req high until it sees its one-cycle ack;
  // gnt marks the requester owning the decoder in EVAL and RESP.
  assign pick = rr_pick(8'(req), 3'(ptr_q), N);

  decoder38 u_dec (
    .a   (op_sel_q),
    .y_n (dec_n)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick.found) state_d = ST_EVAL;
      ST_EVAL: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt       = '0;
    ack       = '0;
    result_id = '0;
    busy      = (state_q != ST_IDLE);
    if (busy) gnt[g_q] = 1'b1;
    if (state_q == ST_RESP) begin
      ack[g_q]  = 1'b1;
      result_id = g_q;
    end
  end

  assign result = result_q;

  // Operands are captured only when leaving IDLE; later changes are ignored.
  always_comb begin
    g_d       = g_q;
    op_sel_d  = op_sel_q;
    op_mask_d = op_mask_q;
    ptr_d     = ptr_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (pick.found) begin
          g_d       = IDW'(pick.idx);
          op_sel_d  = sel[SEL_W*int'(g_d) +: SEL_W];
          op_mask_d = mask[MINT_W*int'(g_d) +: MINT_W];
        end
      end
      // Unselected minterms are forced high so they drop out of the NAND.
      ST_EVAL: result_d = ~&(dec_n | ~op_mask_q);
      ST_RESP: ptr_d = (g_q == IDW'(N - 1)) ? '0 : g_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= '0;
      g_q       <= '0;
      op_sel_q  <= '0;
      op_mask_q <= '0;
      result_q  <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      g_q       <= g_d;
      op_sel_q  <= op_sel_d;
      op_mask_q <= op_mask_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_sop_arbiter.sv
// Directed bench for sop_arbiter: reset, single requests, truth sweep,
// round-robin order/spacing, operand latching, reset mid-transaction, edge masks.
module tb_sop_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [3*N-1:0] sel;
  logic [8*N-1:0] mask;
  logic [N-1:0]  gnt;
  logic [N-1:0]  ack;
  logic          result;
  logic [1:0]    result_id;
  logic          busy;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];

  sop_arbiter #(.N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .sel       (sel),
    .mask      (mask),
    .gnt       (gnt),
    .ack       (ack),
    .result    (result),
    .result_id (result_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int id, input logic [2:0] s, input logic [7:0] m);
    sel[3*id +: 3]  = s;
    mask[8*id +: 8] = m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_id", 32'(result_id), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One isolated transaction; checks latency, grant and response.
  task automatic run_one(input string tag, input int id, input logic [2:0] s,
                         input logic [7:0] m, input logic exp_r);
    logic [N-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    set_op(id, s, m);
    @(negedge clk);
    req[id] = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_eval_gnt"}, 32'(gnt), 32'(oh));
    chk({tag, "_eval_ack"}, 32'(ack), 0);
    @(posedge clk); #1;
    chk({tag, "_ack"}, 32'(ack), 32'(oh));
    chk({tag, "_gnt"}, 32'(gnt), 32'(oh));
    chk({tag, "_result"}, 32'(result), 32'(exp_r));
    chk({tag, "_id"}, 32'(result_id), 32'(id));
    @(negedge clk);
    req[id] = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    logic [7:0] sweep_exp;
    int cyc, last, nack;
    logic [31:0] e;

    reset_n = 1'b0;
    req  = '0;
    sel  = '0;
    mask = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // F1 = minterms 2,4,7 at sel=2
    run_one("single", 0, 3'b010, 8'b1001_0100, 1'b1);

    // F2 = minterms 0,3 swept over all inputs
    sweep_exp = 8'b0000_1001;
    for (int s = 0; s < 8; s++)
      run_one("sweep", 1, 3'(s), 8'b0000_1001, sweep_exp[s]);

    // All four requesting continuously from reset
    do_reset();
    set_op(0, 3'd0, 8'h01);
    set_op(1, 3'd1, 8'h00);
    set_op(2, 3'd2, 8'h04);
    set_op(3, 3'd3, 8'hF0);
    exp_q = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    @(negedge clk);
    req  = 4'hF;
    cyc  = 0;
    last = -1;
    nack = 0;
    while (nack < 5 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (ack != 0) begin
        e = exp_q.pop_front();
        chk("rr_id", 32'(result_id), e);
        chk("rr_ack", 32'(ack), 32'(4'b0001 << e));
        if (last >= 0) chk("rr_gap", 32'(cyc - last), 3);
        else           chk("rr_first", 32'(cyc), 2);
        last = cyc;
        nack++;
      end
    end
    if (nack < 5) chk("rr_timeout", 32'(nack), 5);
    @(negedge clk);
    req = '0;
    repeat (3) @(posedge clk);

    // Operand change after grant must not affect the result
    set_op(2, 3'd7, 8'h80);
    @(negedge clk);
    req[2] = 1'b1;
    @(posedge clk); #1;
    chk("latch_eval_gnt", 32'(gnt), 32'h4);
    sel[8:6] = 3'd0;
    @(posedge clk); #1;
    chk("latch_ack", 32'(ack), 32'h4);
    chk("latch_result", 32'(result), 1);
    @(negedge clk);
    req = '0;
    sel[8:6] = 3'd7;
    @(posedge clk);

    // Serve requester 1 so ptr=2, then reset while requester 0 is in EVAL
    run_one("pre_rst", 1, 3'd3, 8'h09, 1'b1);
    set_op(0, 3'd7, 8'h80);
    set_op(3, 3'd4, 8'h20);
    @(negedge clk);
    req = 4'b0001;
    @(posedge clk); #1;
    chk("mid_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_gnt", 32'(gnt), 0);
    chk("mid_ack", 32'(ack), 0);
    chk("mid_busy0", 32'(busy), 0);
    chk("mid_result", 32'(result), 0);
    chk("mid_id", 32'(result_id), 0);
    @(posedge clk); #1;
    chk("mid_hold_ack", 32'(ack), 0);
    @(negedge clk);
    reset_n = 1'b1;
    req = 4'b1010;
    @(posedge clk); #1;
    chk("post_gnt", 32'(gnt), 32'h2);
    @(posedge clk); #1;
    chk("post_ack", 32'(ack), 32'h2);
    chk("post_id", 32'(result_id), 1);
    chk("post_result", 32'(result), 1);
    @(negedge clk);
    req[1] = 1'b0;
    @(posedge clk); #1;
    chk("post_idle_ack", 32'(ack), 0);
    @(posedge clk); #1;
    chk("post3_gnt", 32'(gnt), 32'h8);
    @(posedge clk); #1;
    chk("post3_ack", 32'(ack), 32'h8);
    chk("post3_id", 32'(result_id), 3);
    chk("post3_result", 32'(result), 0);
    @(negedge clk);
    req = '0;
    @(posedge clk);

    // Edge masks
    for (int s = 0; s < 8; s++) run_one("mask00", 3, 3'(s), 8'h00, 1'b0);
    for (int s = 0; s < 8; s++) run_one("maskff", 3, 3'(s), 8'hFF, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
